// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and operation codes for the serial add/sub unit
package addsub_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/fulladder.sv
// fulladder: single-bit full adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/addsub4_serial.sv
// addsub4_serial: bit-serial signed add/subtract through one full-adder slice
module addsub4_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic [WIDTH:0]   num
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic             r_carry;
  logic             r_cmsb;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_cout;
  logic             w_last;
  logic             w_ovf;
  fulladder u_fa (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .cin (r_carry),
    .s   (w_s),
    .cout(w_cout)
  );
  assign w_last = r_cnt == CW'(WIDTH - 1);
  // In DONE the carry flop holds the carry out of the MSB slice
  assign w_ovf  = r_cmsb ^ r_carry;
  // Control FSM, operand/sum shift registers and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_carry <= 1'b0;
      r_cmsb  <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
      num     <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_a     <= a;
          r_b     <= (op == OP_SUB) ? ~b : b;
          r_carry <= (op == OP_SUB) ? ~c_in : c_in;
          r_cnt   <= '0;
          r_sh    <= '0;
          busy    <= 1'b1;
          r_state <= RUN;
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sh    <= {w_s, r_sh[WIDTH-1:1]};
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cmsb  <= r_carry;
            busy    <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          sum     <= r_sh;
          c_out   <= r_carry;
          ovf     <= w_ovf;
          num     <= {r_sh[WIDTH-1] ^ w_ovf, r_sh};
          done    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/addsub4_serial.md
# addsub4_serial

Bit-serial signed add/subtract unit: accepts one operand pair per start pulse, computes a ± b ± c_in over WIDTH clock cycles through a single full-adder slice, then presents a registered result with a one-cycle done pulse. It is the sequential, handshaked counterpart of the combinational add/sub datapath. It acts as the consumer side of operand streams produced by stimulus or sequencer logic, and trades latency for area.

## Interface
- WIDTH, default 4: operand and sum width in bits, minimum 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = add, 1 = subtract; latched with start.
- a  in  WIDTH  signed operand; latched with start.
- b  in  WIDTH  signed operand; latched with start.
- c_in  in  1  carry-in (add) or borrow-in (subtract); latched with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result registers update.
- sum  out  WIDTH  signed result, low WIDTH bits.
- c_out  out  1  raw carry out of the MSB slice.
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- num  out  WIDTH+1  exact signed result = {sum[MSB] ^ ovf, sum}.

## Operation
- Arithmetic, with b_eff = op ? ~b : b and seed = op ? ~c_in : c_in:
  - sum = a + b_eff + seed, computed modulo 2^WIDTH.
  - Add: a + b + c_in.
  - Subtract: a − b − c_in.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start = 1, latch a, b_eff, seed (into the carry flop), clear the bit counter, and go to RUN.
  - RUN: each cycle, the full-adder slice takes the current LSBs of the a and b_eff shift registers plus the carry flop. The sum bit shifts into the MSB of the sum shift register. Carry flop and counter update. Capture the carry into the MSB as the final slice is processed. After counter = WIDTH−1, go to DONE.
  - DONE: load sum, c_out, ovf, num result registers; done = 1; go to IDLE.
- start in RUN or DONE is ignored; it is not queued.
- Result registers hold their value until the next DONE. They never show partial sums.
- Reset values: state IDLE; busy, done, sum, c_out, ovf, num, counter, and shift registers all 0.
- Reset mid-operation: immediate abort, all outputs 0, no done pulse for the aborted request.

## Timing
- Start sampled at edge k. busy = 1 from edge k through edge k+WIDTH.
- Bit i is processed at edge k+1+i.
- Enter DONE at edge k+WIDTH. done and the new result are visible from edge k+WIDTH+1 for one cycle (done), while the result persists.
- Latency: start edge to done-high = WIDTH+1 cycles. For WIDTH = 4 this is 5.
- Throughput: with start held high, one op per WIDTH+2 cycles. The next start is accepted in the IDLE cycle after DONE.
- busy and done are never high simultaneously.

## Structure
- Shared package addsub_pkg holds:
  - The state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
- One sub-module: instantiate the codebase's existing fulladder cell as the single bit slice (a, b, cin → s, cout). All other logic is inline: FSM, shift registers, counter of width $clog2(WIDTH), and result registers.

## Test plan
All cases use WIDTH = 4.
- Add 5 + 0, c_in = 0: sum = 0101, c_out = 0, ovf = 0, num = 5. done is high exactly 5 cycles after the start edge, for 1 cycle.
- Subtract 5 − 7, c_in = 0: sum = 1110, c_out = 0, ovf = 0, num = −2.
- Add 7 + 1 → sum = 1000, ovf = 1, num = +8 (01000). Then add 3 + 4 with c_in = 1 → sum = 1000, ovf = 1, num = +8.
- Subtract −8 − 1, c_in = 0: sum = 0111, c_out = 1, ovf = 1, num = −9 (10111). Subtract 3 − 1, c_in = 1: sum = 0001, c_out = 1, ovf = 0, num = 1.
- Pulse start again 2 cycles into RUN with different operands: ignored; the first result is delivered unchanged. Holding start high yields done pulses every 6 cycles.
- Assert rst during the 2nd RUN cycle: busy, done, sum, and num are 0 immediately, and no done pulse follows. A fresh start after rst deasserts completes normally.
